pixel_stream_tx: RTL and testbench

- Downstream consumer of the pong video stream: p_tick, hsync, vsync and the 12-bit rgb from pixel_gen.
- Run-length encodes pixels into tokens, buffers them in a small FIFO, and presents them on a valid/ready token bus.
- The bus lets an off-chip FPGA or host reconstruct the frame through a narrow, backpressured link instead of the raw VGA pins.

---
 rtl/pixel_stream_pkg.sv | 36 +++
 rtl/pixel_stream_fifo.sv | 58 +++++
 rtl/pixel_stream_tx.sv | 186 ++++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg: token layout, kinds and encoder states shared
// by the pixel stream run-length encoder and its token FIFO.
package pixel_stream_pkg;

  localparam int PS_RGB_W   = 12;
  localparam int PS_RUN_W   = 4;
  localparam int PS_FIFO_AW = 3;
  localparam int PS_TOK_W   = 2 + PS_RUN_W + PS_RGB_W;

  localparam int PS_RGB_LSB  = 0;
  localparam int PS_RUN_LSB  = PS_RGB_W;
  localparam int PS_KIND_LSB = PS_RGB_W + PS_RUN_W;

  localparam logic [1:0] KIND_RUN  = 2'b00;
  localparam logic [1:0] KIND_SYNC = 2'b01;

  typedef enum logic [1:0] {
    IDLE_NO_RUN,
    RUN_OPEN,
    SYNC_PENDING
  } enc_state_t;

  function automatic logic [PS_TOK_W-1:0] pack_token(
    input logic [1:0]          kind,
    input logic [PS_RUN_W-1:0] run,
    input logic [PS_RGB_W-1:0] rgb
  );
    logic [PS_TOK_W-1:0] tok;
    tok = '0;
    tok[PS_KIND_LSB +: 2]       = kind;
    tok[PS_RUN_LSB +: PS_RUN_W] = run;
    tok[PS_RGB_LSB +: PS_RGB_W] = rgb;
    return tok;
  endfunction

endpackage

// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo: show-ahead synchronous FIFO for stream tokens.
// A push into a full FIFO only lands when a pop frees a slot.
module pixel_stream_fifo
  import pixel_stream_pkg::*;
#(
  parameter int W  = PS_TOK_W,
  parameter int AW = PS_FIFO_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rd_ok = pop & ~empty;
  assign wr_ok = push & (~full | rd_ok);
  assign head  = mem[rd_ptr_q];
  assign level = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Token storage; contents are only observed while level != 0.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: packs the VGA pixel stream into RUN/SYNC tokens.
// PIXEL_STREAM_TX_RLE_EN enables run-length merging of equal pixels.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int RGB_W   = PS_RGB_W,
  parameter int RUN_W   = PS_RUN_W,
  parameter int FIFO_AW = PS_FIFO_AW,
  localparam int TOK_W  = 2 + RUN_W + RGB_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [RGB_W-1:0]   rgb,
  output logic [TOK_W-1:0]   tok_data,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  enc_state_t state_q;
  enc_state_t state_d;

  logic             prev_hs_q;
  logic             prev_vs_q;
  logic             hs_rise;
  logic             vs_rise;
  logic             sync_edge;
  logic [1:0]       sync_q;
  logic [1:0]       sync_d;
  logic [TOK_W-1:0] sync_now_tok;
  logic [TOK_W-1:0] sync_pend_tok;

  logic             push;
  logic [TOK_W-1:0] push_data;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

`ifdef PIXEL_STREAM_TX_RLE_EN
  logic [RUN_W-1:0] run_cnt_q;
  logic [RUN_W-1:0] run_cnt_d;
  logic [RGB_W-1:0] run_rgb_q;
  logic [RGB_W-1:0] run_rgb_d;
  logic             run_full;
  logic             colour_change;
  logic [TOK_W-1:0] run_tok;

  assign run_full      = (run_cnt_q == '1);
  assign colour_change = (rgb != run_rgb_q);
  assign run_tok       = pack_token(KIND_RUN, run_cnt_q, run_rgb_q);
`endif

  assign hs_rise   = hsync & ~prev_hs_q;
  assign vs_rise   = vsync & ~prev_vs_q;
  assign sync_edge = hs_rise | vs_rise;

  assign sync_now_tok = pack_token(
    KIND_SYNC, {{(RUN_W-2){1'b0}}, vs_rise, hs_rise}, '0);
  assign sync_pend_tok = pack_token(
    KIND_SYNC, {{(RUN_W-2){1'b0}}, sync_q}, '0);

  assign tok_valid = ~fifo_empty;
  assign pop       = tok_valid & tok_ready;

  // Remember sync levels of the last sampled pixel for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_hs_q <= 1'b0;
      prev_vs_q <= 1'b0;
    end else if (p_tick) begin
      prev_hs_q <= hsync;
      prev_vs_q <= vsync;
    end
  end

  // Encoder state, pending sync flags and open-run registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE_NO_RUN;
      sync_q    <= '0;
`ifdef PIXEL_STREAM_TX_RLE_EN
      run_cnt_q <= '0;
      run_rgb_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
`ifdef PIXEL_STREAM_TX_RLE_EN
      run_cnt_q <= run_cnt_d;
      run_rgb_q <= run_rgb_d;
`endif
    end
  end

  // Next-state and token write selection, one FIFO write per cycle.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    push      = 1'b0;
    push_data = '0;
`ifdef PIXEL_STREAM_TX_RLE_EN
    run_cnt_d = run_cnt_q;
    run_rgb_d = run_rgb_q;
`endif
    unique case (state_q)
      IDLE_NO_RUN: begin
        if (p_tick) begin
`ifdef PIXEL_STREAM_TX_RLE_EN
          push      = sync_edge;
          push_data = sync_now_tok;
          run_cnt_d = '0;
          run_rgb_d = rgb;
          state_d   = RUN_OPEN;
`else
          push      = 1'b1;
          push_data = pack_token(KIND_RUN, '0, rgb);
          if (sync_edge) begin
            sync_d  = {vs_rise, hs_rise};
            state_d = SYNC_PENDING;
          end
`endif
        end
      end
      RUN_OPEN: begin
`ifdef PIXEL_STREAM_TX_RLE_EN
        if (p_tick) begin
          if (sync_edge || colour_change || run_full) begin
            push      = 1'b1;
            push_data = run_tok;
            run_cnt_d = '0;
            run_rgb_d = rgb;
          end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
          if (sync_edge) begin
            sync_d  = {vs_rise, hs_rise};
            state_d = SYNC_PENDING;
          end
        end
`else
        state_d = IDLE_NO_RUN;
`endif
      end
      SYNC_PENDING: begin
        push      = 1'b1;
        push_data = sync_pend_tok;
        sync_d    = '0;
`ifdef PIXEL_STREAM_TX_RLE_EN
        state_d   = RUN_OPEN;
`else
        state_d   = IDLE_NO_RUN;
`endif
      end
      default: state_d = IDLE_NO_RUN;
    endcase
  end

  // Sticky flag: a token was dropped on a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  pixel_stream_fifo #(
    .W  (TOK_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (tok_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: directed and random pixel streams against a
// queue-based token model, with literal checks on directed cases.
module tb_pixel_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        p_tick = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [11:0] rgb = 12'h000;
  logic        tok_ready = 1'b0;
  logic [17:0] tok_data;
  logic        tok_valid;
  logic [3:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int max_lvl = 0;

  logic [17:0] plog[$];
  logic [11:0] pal [4] = '{12'h000, 12'hFFF, 12'hF00, 12'h00F};

`ifdef PIXEL_STREAM_TX_RLE_EN
  localparam int NQ = 4;
`else
  localparam int NQ = 3;
`endif

  pixel_stream_tx dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .tok_data   (tok_data),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] t_run(input int n, input logic [11:0] c);
    return {2'b00, 4'(n), c};
  endfunction

  function automatic logic [17:0] t_sync(input logic h, input logic v);
    return {2'b01, 2'b00, v, h, 12'h000};
  endfunction

  function automatic logic [17:0] lg(input int i);
    return (i < plog.size()) ? plog[i] : 18'h3FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Behavioural model: token list per pixel, then an 8-deep queue.
  logic [17:0] mq[$];
  logic        m_ovf;
  bit          pend_v;
  logic [17:0] pend_t;
  bit          have_run;
  int          run_len;
  logic [11:0] run_col;
  logic        m_phs;
  logic        m_pvs;

  function automatic void model_clear();
    mq.delete();
    m_ovf    = 1'b0;
    pend_v   = 1'b0;
    pend_t   = '0;
    have_run = 1'b0;
    run_len  = 0;
    run_col  = '0;
    m_phs    = 1'b0;
    m_pvs    = 1'b0;
  endfunction

  task automatic model_step();
    logic [17:0] w[$];
    logic [17:0] l[$];
    bit do_pop;
    bit hr;
    bit vr;
    do_pop = (mq.size() != 0) && tok_ready;
    if (pend_v) begin
      w.push_back(pend_t);
      pend_v = 1'b0;
    end
    if (p_tick) begin
      hr = hsync && !m_phs;
      vr = vsync && !m_pvs;
      m_phs = hsync;
      m_pvs = vsync;
`ifdef PIXEL_STREAM_TX_RLE_EN
      if (hr || vr) begin
        if (have_run) l.push_back(t_run(run_len - 1, run_col));
        l.push_back(t_sync(hr, vr));
        have_run = 1'b1;
        run_len = 1;
        run_col = rgb;
      end else if (!have_run) begin
        have_run = 1'b1;
        run_len = 1;
        run_col = rgb;
      end else if (rgb != run_col || run_len == 16) begin
        l.push_back(t_run(run_len - 1, run_col));
        run_len = 1;
        run_col = rgb;
      end else begin
        run_len++;
      end
`else
      l.push_back(t_run(0, rgb));
      if (hr || vr) l.push_back(t_sync(hr, vr));
`endif
      if (l.size() > 0) w.push_back(l[0]);
      if (l.size() > 1) begin
        pend_v = 1'b1;
        pend_t = l[1];
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (w.size() > 0) begin
      if (mq.size() < 8) mq.push_back(w[0]);
      else m_ovf = 1'b1;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else model_step();
  end

  // Cycle compare against the model and log of accepted tokens.
  always @(negedge clk) begin
    if (!reset) begin
      check("level", fifo_level, mq.size());
      check("valid", tok_valid, mq.size() != 0);
      check("ovf", overflow, m_ovf);
      if (mq.size() != 0) check("data", tok_data, mq[0]);
      if (int'(fifo_level) > max_lvl) max_lvl = fifo_level;
      if (tok_valid && tok_ready) plog.push_back(tok_data);
    end
  end

  task automatic pix(input logic [11:0] c, input logic h, input logic v);
    @(posedge clk);
    #1;
    p_tick = 1'b1;
    rgb = c;
    hsync = h;
    vsync = v;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    hsync = 1'b0;
    vsync = 1'b0;
    tok_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    plog.delete();
    max_lvl = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit last_pt;
    int n;
    last_pt = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", tok_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);

    do_reset();
    tok_ready = 1'b1;
    repeat (20) pix(12'hF00, 1'b0, 1'b0);
    pix(12'h0F0, 1'b0, 1'b0);
    idle(6);
`ifdef PIXEL_STREAM_TX_RLE_EN
    check("s1_n", plog.size(), 2);
    check("s1_t0", lg(0), t_run(15, 12'hF00));
    check("s1_t1", lg(1), t_run(3, 12'hF00));
`else
    check("s1_n", plog.size(), 21);
    check("s1_t0", lg(0), t_run(0, 12'hF00));
    check("s1_t20", lg(20), t_run(0, 12'h0F0));
`endif
    check("s1_ovf", overflow, 0);

    do_reset();
    tok_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      pix((i % 2) ? 12'hFFF : 12'h000, 1'b0, 1'b0);
    idle(6);
`ifdef PIXEL_STREAM_TX_RLE_EN
    check("s2_n", plog.size(), 5);
`else
    check("s2_n", plog.size(), 6);
    check("s2_t5", lg(5), t_run(0, 12'hFFF));
`endif
    check("s2_t0", lg(0), t_run(0, 12'h000));
    check("s2_t1", lg(1), t_run(0, 12'hFFF));
    check("s2_t4", lg(4), t_run(0, 12'h000));
    check("s2_maxlvl", max_lvl, 1);

    do_reset();
    tok_ready = 1'b1;
    repeat (5) pix(12'h00F, 1'b0, 1'b0);
    pix(12'h0F0, 1'b1, 1'b0);
    @(negedge clk);
    check("s3_lat_v", tok_valid, 1);
`ifdef PIXEL_STREAM_TX_RLE_EN
    check("s3_lat_d", tok_data, t_run(4, 12'h00F));
    idle(6);
    check("s3_n", plog.size(), 2);
    check("s3_t1", lg(1), t_sync(1'b1, 1'b0));
`else
    check("s3_lat_d", tok_data, t_run(0, 12'h0F0));
    idle(6);
    check("s3_n", plog.size(), 7);
    check("s3_t6", lg(6), t_sync(1'b1, 1'b0));
`endif

    do_reset();
    tok_ready = 1'b1;
    pix(12'h0AA, 1'b0, 1'b0);
    pix(12'h0AA, 1'b1, 1'b1);
    idle(6);
`ifdef PIXEL_STREAM_TX_RLE_EN
    check("s4_n", plog.size(), 2);
    check("s4_t0", lg(0), t_run(0, 12'h0AA));
    check("s4_t1", lg(1), t_sync(1'b1, 1'b1));
`else
    check("s4_n", plog.size(), 3);
    check("s4_t1", lg(1), t_run(0, 12'h0AA));
    check("s4_t2", lg(2), t_sync(1'b1, 1'b1));
`endif

    do_reset();
    for (int i = 0; i < 10; i++)
      pix((i % 2) ? 12'hFFF : 12'h000, 1'b0, 1'b0);
    idle(2);
    check("s5_level", fifo_level, 8);
    check("s5_ovf", overflow, 1);
    pix(12'h123, 1'b0, 1'b0);
    idle(2);
    check("s5_ovf_sticky", overflow, 1);
    check("s5_level2", fifo_level, 8);
    tok_ready = 1'b1;
    n = 0;
    while (tok_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("s5_drain_done", tok_valid, 0);
    check("s5_n", plog.size(), 8);
    check("s5_t0", lg(0), t_run(0, 12'h000));
    check("s5_t1", lg(1), t_run(0, 12'hFFF));
    check("s5_t7", lg(7), t_run(0, 12'hFFF));
    check("s5_ovf_after", overflow, 1);

    do_reset();
    for (int i = 0; i < NQ; i++)
      pix(((NQ - 1 - i) % 2 == 0) ? 12'hFFF : 12'h000, 1'b0, 1'b0);
    idle(1);
    check("s6_queued", fifo_level, 3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("s6_rst_valid", tok_valid, 0);
    check("s6_rst_level", fifo_level, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    plog.delete();
    tok_ready = 1'b1;
    repeat (3) pix(12'hFFF, 1'b0, 1'b0);
    pix(12'h0F0, 1'b0, 1'b0);
    idle(6);
`ifdef PIXEL_STREAM_TX_RLE_EN
    check("s6_fresh", lg(0), t_run(2, 12'hFFF));
`else
    check("s6_fresh", lg(0), t_run(0, 12'hFFF));
`endif
    check("s6_ovf", overflow, 0);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (c >= 1000 && c < 1600)
        tok_ready = ($urandom_range(0, 9) < 2);
      else
        tok_ready = ($urandom_range(0, 9) < 6);
      if (last_pt) p_tick = 1'b0;
      else p_tick = ($urandom_range(0, 2) != 0);
      if (p_tick) begin
        if ($urandom_range(0, 3) == 0) rgb = pal[$urandom_range(0, 3)];
        if ($urandom_range(0, 7) == 0) hsync = ~hsync;
        if ($urandom_range(0, 19) == 0) vsync = ~vsync;
      end
      last_pt = p_tick;
    end
    p_tick = 1'b0;
    tok_ready = 1'b1;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
